spmv_sched: RTL and testbench

Sequencer for the sparse matrix-vector multiply datapath. It runs the source-vector RAM in two phases. In the load phase it accepts MAT_RANK vector elements and generates RAM write addresses. In the compute phase it accepts one ELL-format sparse row (4 column indices) per handshake and issues two read-address pairs on the dual-port RAM. It then emits lane-aligned valid, lane-select and row-last strobes to the downstream complex MAC. Vector and matrix data words bypass this block; only control, addresses and indices pass through it.

---
 rtl/spmv_pkg.sv | 32 +++
 rtl/spmv_sched_if.sv | 38 +++
 rtl/spmv_lat_pipe.sv | 25 ++
 rtl/spmv_sched.sv | 177 +++++++++++++++++
 tb/tb_spmv_sched.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spmv_pkg.sv
// Shared types and helpers for the spmv_sched sequencer.
package spmv_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned MAX_AW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN
  } state_t;

  // Bundle sub-phase inside RUN: wait for a bundle, issue lanes 0/1, issue lanes 2/3.
  typedef enum logic [1:0] {
    PH_WAIT = 2'd0,
    PH_LO   = 2'd1,
    PH_HI   = 2'd2
  } phase_t;

  // Extract lane k of aw bits from a lane-packed index bus.
  function automatic logic [MAX_AW-1:0] lane_slice(input logic [LANES*MAX_AW-1:0] bus,
                                                   input int unsigned aw,
                                                   input int unsigned k);
    logic [LANES*MAX_AW-1:0] sh;
    logic [MAX_AW:0]         mask;
    sh         = bus >> (k * aw);
    mask       = ((MAX_AW + 1)'(1) << aw) - (MAX_AW + 1)'(1);
    lane_slice = sh[MAX_AW-1:0] & mask[MAX_AW-1:0];
  endfunction

endpackage

// File: rtl/spmv_sched_if.sv
// Vector-load, sparse-row, RAM-port and MAC-strobe signals of spmv_sched.
interface spmv_sched_if
  import spmv_pkg::*;
#(
  parameter int unsigned AW = 8
);

  logic                  src_vld;
  logic                  src_rdy;
  logic                  ram_we;
  logic [AW-1:0]         ram_waddr;
  logic                  S_vld;
  logic                  S_rdy;
  logic [LANES*AW-1:0]   Scol_index;
  logic                  ram_ena;
  logic                  ram_enb;
  logic [AW-1:0]         ram_addra;
  logic [AW-1:0]         ram_addrb;
  logic                  mac_vld;
  logic                  mac_lane;
  logic                  mac_row_last;
  logic [AW-1:0]         mac_row;

  modport master (
    input  src_vld, S_vld, Scol_index,
    output src_rdy, ram_we, ram_waddr, S_rdy,
           ram_ena, ram_enb, ram_addra, ram_addrb,
           mac_vld, mac_lane, mac_row_last, mac_row
  );

  modport slave (
    output src_vld, S_vld, Scol_index,
    input  src_rdy, ram_we, ram_waddr, S_rdy,
           ram_ena, ram_enb, ram_addra, ram_addrb,
           mac_vld, mac_lane, mac_row_last, mac_row
  );

endinterface

// File: rtl/spmv_lat_pipe.sv
// DEPTH-stage register delay line with synchronous clear.
module spmv_lat_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/spmv_sched.sv
// Two-phase (load / compute) sequencer for the SpMV source-vector RAM.
// Optional index range check: define SPMV_IDX_CHK_EN to add idx_err.
module spmv_sched
  import spmv_pkg::*;
#(
  parameter int unsigned MAT_RANK = 256,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
`ifdef SPMV_IDX_CHK_EN
  output logic idx_err,
`endif
  spmv_sched_if.master bus
);

  localparam int unsigned AW = $clog2(MAT_RANK);

  state_t          r_state, w_state_nxt;
  phase_t          r_ph, w_ph_nxt;
  logic [AW-1:0]   r_wcnt;
  logic [AW:0]     r_rows;
  logic [AW-1:0]   r_cur_row;
  logic [AW-1:0]   r_addra, r_addrb, r_lane2, r_lane3;
  logic [2:0]      r_dcnt;
  logic            r_done;

  logic            w_src_rdy, w_src_acc, w_s_rdy, w_s_acc;
  logic            w_rows_full, w_issue, w_hi, w_drain_end;
  logic [AW-1:0]   w_raw  [LANES];
  logic [AW-1:0]   w_lane [LANES];
  logic [AW+2:0]   w_pipe_d, w_pipe_q;
`ifdef SPMV_IDX_CHK_EN
  logic [LANES-1:0] w_bad;
  logic             r_idx_err;
`endif

  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      w_raw[k] = AW'(lane_slice((LANES*MAX_AW)'(bus.Scol_index), AW, k));
`ifdef SPMV_IDX_CHK_EN
      w_bad[k]  = {1'b0, w_raw[k]} >= (AW+1)'(MAT_RANK);
      w_lane[k] = w_bad[k] ? '0 : w_raw[k];
`else
      w_lane[k] = w_raw[k];
`endif
    end
  end

  assign w_src_rdy   = (r_state == S_LOAD);
  assign w_src_acc   = bus.src_vld & w_src_rdy;
  assign w_rows_full = (r_rows == (AW+1)'(MAT_RANK));
  assign w_s_rdy     = (r_state == S_RUN) & ((r_ph == PH_WAIT) | (r_ph == PH_HI)) & ~w_rows_full;
  assign w_s_acc     = bus.S_vld & w_s_rdy;
  assign w_issue     = (r_state == S_RUN) & ((r_ph == PH_LO) | (r_ph == PH_HI));
  assign w_hi        = (r_ph == PH_HI);
  assign w_drain_end = (r_state == S_DRAIN) & (r_dcnt == 3'(RD_LAT - 1));

  assign bus.src_rdy   = w_src_rdy;
  assign bus.ram_we    = w_src_acc;
  assign bus.ram_waddr = r_wcnt;
  assign bus.S_rdy     = w_s_rdy;
  assign bus.ram_ena   = w_issue;
  assign bus.ram_enb   = w_issue;
  assign bus.ram_addra = r_addra;
  assign bus.ram_addrb = r_addrb;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
`ifdef SPMV_IDX_CHK_EN
  assign idx_err       = r_idx_err;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_src_acc && r_wcnt == AW'(MAT_RANK - 1)) begin
                 w_state_nxt = S_RUN;
                 w_ph_nxt    = PH_WAIT;
               end
      S_RUN: begin
        case (r_ph)
          PH_WAIT: if (w_s_acc) w_ph_nxt = PH_LO;
          PH_LO:   w_ph_nxt = PH_HI;
          PH_HI: begin
            if (w_s_acc) begin
              w_ph_nxt = PH_LO;
            end else if (w_rows_full) begin
              w_state_nxt = S_DRAIN;
              w_ph_nxt    = PH_WAIT;
            end else begin
              w_ph_nxt = PH_WAIT;
            end
          end
          default: w_ph_nxt = PH_WAIT;
        endcase
      end
      S_DRAIN: if (w_drain_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ph    <= PH_WAIT;
    end else begin
      r_state <= w_state_nxt;
      r_ph    <= w_ph_nxt;
    end
  end

  // Lanes 2/3 are parked on accept and moved onto the ports during the lane-0/1 cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt    <= '0;
      r_rows    <= '0;
      r_cur_row <= '0;
      r_addra   <= '0;
      r_addrb   <= '0;
      r_lane2   <= '0;
      r_lane3   <= '0;
      r_dcnt    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_drain_end;
      if (r_state == S_IDLE && start) begin
        r_wcnt <= '0;
        r_rows <= '0;
      end
      if (w_src_acc) r_wcnt <= r_wcnt + 1'b1;
      if (w_s_acc) begin
        r_rows    <= r_rows + 1'b1;
        r_cur_row <= r_rows[AW-1:0];
        r_addra   <= w_lane[0];
        r_addrb   <= w_lane[1];
        r_lane2   <= w_lane[2];
        r_lane3   <= w_lane[3];
      end else if (r_state == S_RUN && r_ph == PH_LO) begin
        r_addra <= r_lane2;
        r_addrb <= r_lane3;
      end
      r_dcnt <= (r_state == S_DRAIN) ? r_dcnt + 1'b1 : '0;
    end
  end

`ifdef SPMV_IDX_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx_err <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_idx_err <= 1'b0;
    end else if (w_s_acc && |w_bad) begin
      r_idx_err <= 1'b1;
    end
  end
`endif

  assign w_pipe_d = w_issue ? {1'b1, w_hi, w_hi, r_cur_row} : '0;

  spmv_lat_pipe #(
    .DEPTH (RD_LAT),
    .W     (AW + 3)
  ) u_lat_pipe (
    .clk   (clk),
    .i_clr (rst),
    .i_d   (w_pipe_d),
    .o_q   (w_pipe_q)
  );

  assign {bus.mac_vld, bus.mac_lane, bus.mac_row_last, bus.mac_row} = w_pipe_q;

endmodule

// File: tb/tb_spmv_sched.sv
// Randomized bench: two spmv_sched instances (RD_LAT 1 and 3) on shared stimulus vs a job-level model.
module tb_spmv_sched;

  localparam int N    = 16;
  localparam int AWT  = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic src_vld = 1'b0;
  logic S_vld = 1'b0;
  logic [4*AWT-1:0] scol = '0;
  logic busy1, done1, busy3, done3;
`ifdef SPMV_IDX_CHK_EN
  logic idx_err1, idx_err3;
`endif

  spmv_sched_if #(.AW(AWT)) if1 ();
  spmv_sched_if #(.AW(AWT)) if3 ();

  assign if1.src_vld    = src_vld;
  assign if1.S_vld      = S_vld;
  assign if1.Scol_index = scol;
  assign if3.src_vld    = src_vld;
  assign if3.S_vld      = S_vld;
  assign if3.Scol_index = scol;

  spmv_sched #(.MAT_RANK(N), .RD_LAT(LAT0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
`ifdef SPMV_IDX_CHK_EN
    .idx_err(idx_err1),
`endif
    .bus(if1.master)
  );

  spmv_sched #(.MAT_RANK(N), .RD_LAT(LAT1)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .busy(busy3), .done(done3),
`ifdef SPMV_IDX_CHK_EN
    .idx_err(idx_err3),
`endif
    .bus(if3.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Job-level model: phase of the job, counts, and a cycle-indexed issue schedule.
  int  mode = 0;            // 0 none, 1 loading, 2 accepting rows
  int  wr_cnt = 0;
  int  rows_acc = 0;
  bit  acc_prev = 1'b0;
  bit  m_busy [2] = '{1'b0, 1'b0};
  int  done_cyc [2] = '{-1, -1};
  int  iss_a [int];
  int  iss_b [int];
  int  iss_lane [int];
  int  iss_row [int];
  bit  chk_en = 1'b0;

  int  n_wr = 0;
  int  n_macv [2] = '{0, 0};
  int  n_last [2] = '{0, 0};
  int  n_done [2] = '{0, 0};

  task automatic cmp_dut(input int k, input logic b, input logic d,
                         input logic ena, input logic enb,
                         input logic [AWT-1:0] aa, input logic [AWT-1:0] ab,
                         input logic mv, input logic ml, input logic mlast,
                         input logic [AWT-1:0] mrow,
                         input logic srdy, input logic we, input logic [AWT-1:0] wa,
                         input logic s_rdy);
    int  lat;
    bit  e_iss, e_mac;
    string p;
    lat   = (k == 0) ? LAT0 : LAT1;
    p     = (k == 0) ? "lat1" : "lat3";
    e_iss = iss_a.exists(cyc);
    e_mac = iss_a.exists(cyc - lat);
    chk({p, "_busy"}, 32'(b), 32'(m_busy[k]));
    chk({p, "_done"}, 32'(d), 32'(cyc == done_cyc[k]));
    chk({p, "_ena"}, 32'(ena), 32'(e_iss));
    chk({p, "_enb"}, 32'(enb), 32'(e_iss));
    if (e_iss) begin
      chk({p, "_addra"}, 32'(aa), 32'(iss_a[cyc]));
      chk({p, "_addrb"}, 32'(ab), 32'(iss_b[cyc]));
    end
    chk({p, "_mac_vld"}, 32'(mv), 32'(e_mac));
    if (e_mac) begin
      chk({p, "_mac_lane"}, 32'(ml), 32'(iss_lane[cyc - lat]));
      chk({p, "_mac_last"}, 32'(mlast), 32'(iss_lane[cyc - lat]));
      chk({p, "_mac_row"}, 32'(mrow), 32'(iss_row[cyc - lat]));
    end
    chk({p, "_src_rdy"}, 32'(srdy), 32'(mode == 1));
    chk({p, "_ram_we"}, 32'(we), 32'(src_vld && mode == 1));
    if (we) chk({p, "_waddr"}, 32'(wa), 32'(wr_cnt));
    chk({p, "_S_rdy"}, 32'(s_rdy), 32'(mode == 2 && rows_acc < N && !acc_prev));
    if (mv) n_macv[k]++;
    if (mlast) n_last[k]++;
    if (d) n_done[k]++;
    if (k == 0 && we) n_wr++;
  endtask

  task automatic model_step();
    int  cur;
    bit  acc;
    cur = mode;
    acc = 1'b0;
    if (rst) begin
      mode = 0; wr_cnt = 0; rows_acc = 0; acc_prev = 1'b0;
      m_busy = '{1'b0, 1'b0};
      done_cyc = '{-1, -1};
      iss_a.delete(); iss_b.delete(); iss_lane.delete(); iss_row.delete();
    end else begin
      if (start && !m_busy[0] && !m_busy[1]) begin
        mode = 1; wr_cnt = 0; rows_acc = 0;
        m_busy = '{1'b1, 1'b1};
        done_cyc = '{-1, -1};
      end
      if (cur == 1 && src_vld) begin
        wr_cnt++;
        if (wr_cnt == N) mode = 2;
      end
      if (cur == 2 && S_vld && rows_acc < N && !acc_prev) begin
        acc = 1'b1;
        iss_a[cyc+1] = int'(scol[3:0]);   iss_b[cyc+1] = int'(scol[7:4]);
        iss_lane[cyc+1] = 0;               iss_row[cyc+1] = rows_acc;
        iss_a[cyc+2] = int'(scol[11:8]);  iss_b[cyc+2] = int'(scol[15:12]);
        iss_lane[cyc+2] = 1;               iss_row[cyc+2] = rows_acc;
        rows_acc++;
        if (rows_acc == N) begin
          mode = 0;
          done_cyc[0] = cyc + 2 + LAT0 + 1;
          done_cyc[1] = cyc + 2 + LAT1 + 1;
        end
      end
      acc_prev = acc;
      for (int k = 0; k < 2; k++)
        if (m_busy[k] && cyc + 1 == done_cyc[k]) m_busy[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, busy1, done1, if1.ram_ena, if1.ram_enb, if1.ram_addra, if1.ram_addrb,
              if1.mac_vld, if1.mac_lane, if1.mac_row_last, if1.mac_row,
              if1.src_rdy, if1.ram_we, if1.ram_waddr, if1.S_rdy);
      cmp_dut(1, busy3, done3, if3.ram_ena, if3.ram_enb, if3.ram_addra, if3.ram_addrb,
              if3.mac_vld, if3.mac_lane, if3.mac_row_last, if3.mac_row,
              if3.src_rdy, if3.ram_we, if3.ram_waddr, if3.S_rdy);
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // src_mode: 0 continuous, 1 every 3rd cycle (S_vld held during load, pinned bundle), 2 random.
  task automatic do_job(input int src_mode, input bit poke, input int rst_after, input bit rnd_gap);
    int  i, w, first_addr;
    bit  acc, got, pin;
    n_wr = 0; n_macv = '{0, 0}; n_last = '{0, 0}; n_done = '{0, 0};
    start = 1'b1;
    tick();
    start = 1'b0;
    i = 0; w = 0; first_addr = -1;
    while (w < N && i < 500) begin
      case (src_mode)
        0:       src_vld = 1'b1;
        1:       src_vld = (i % 3 == 0);
        default: src_vld = 1'($urandom_range(0, 1));
      endcase
      S_vld = (src_mode == 1);
      scol  = 16'($urandom);
      start = poke && (i == 4);
      @(negedge clk);
      if (if1.ram_we) begin
        if (w == 0) first_addr = int'(if1.ram_waddr);
        w++;
      end
      tick();
      i++;
    end
    src_vld = 1'b0; S_vld = 1'b0; start = 1'b0;
    if (w < N) chk("load_timeout", 32'(w), 32'(N));
    if (src_mode == 0) chk("load_cycles", 32'(i), 32'(N));
    chk("first_waddr", 32'(first_addr), 32'd0);

    for (int r = 0; r < N; r++) begin
      if (rnd_gap) begin
        repeat ($urandom_range(0, 2)) begin
          src_vld = 1'($urandom_range(0, 1));
          tick();
        end
      end
      pin     = (src_mode == 1 && r == 3);
      S_vld   = 1'b1;
      scol    = pin ? 16'hF073 : 16'($urandom);
      src_vld = 1'($urandom_range(0, 1));
      start   = poke && (r == 5);
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        @(negedge clk);
        if (if1.S_rdy) acc = 1'b1;
      end
      if (!acc) begin
        chk("s_rdy_timeout", 32'd0, 32'd1);
        S_vld = 1'b0; start = 1'b0;
        break;
      end
      tick();
      S_vld = 1'b0; start = 1'b0;
      if (pin) begin
        @(negedge clk);
        chk("pin_ena_lo", 32'(if1.ram_ena), 32'd1);
        chk("pin_addra_lo", 32'(if1.ram_addra), 32'd3);
        chk("pin_addrb_lo", 32'(if1.ram_addrb), 32'd7);
        @(negedge clk);
        chk("pin_addra_hi", 32'(if1.ram_addra), 32'd0);
        chk("pin_addrb_hi", 32'(if1.ram_addrb), 32'd15);
        chk("pin_mac1_vld_lo", 32'(if1.mac_vld), 32'd1);
        chk("pin_mac1_lane_lo", 32'(if1.mac_lane), 32'd0);
        chk("pin_mac1_row", 32'(if1.mac_row), 32'd3);
        @(negedge clk);
        chk("pin_mac1_vld_hi", 32'(if1.mac_vld), 32'd1);
        chk("pin_mac1_lane_hi", 32'(if1.mac_lane), 32'd1);
        chk("pin_mac1_last", 32'(if1.mac_row_last), 32'd1);
        @(negedge clk);
        chk("pin_mac3_vld_lo", 32'(if3.mac_vld), 32'd1);
        chk("pin_mac3_lane_lo", 32'(if3.mac_lane), 32'd0);
        @(negedge clk);
        chk("pin_mac3_vld_hi", 32'(if3.mac_vld), 32'd1);
        chk("pin_mac3_last", 32'(if3.mac_row_last), 32'd1);
        tick();
      end
      if (rst_after == r + 1) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_busy3", 32'(busy3), 32'd0);
        chk("rst_mac_vld1", 32'(if1.mac_vld), 32'd0);
        chk("rst_mac_vld3", 32'(if3.mac_vld), 32'd0);
        chk("rst_S_rdy", 32'(if1.S_rdy), 32'd0);
        tick();
        return;
      end
    end
    src_vld = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (done3) got = 1'b1;
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    tick();
    chk("job_writes", 32'(n_wr), 32'(N));
    chk("job_mac_vld1", 32'(n_macv[0]), 32'(2 * N));
    chk("job_mac_vld3", 32'(n_macv[1]), 32'(2 * N));
    chk("job_row_last1", 32'(n_last[0]), 32'(N));
    chk("job_row_last3", 32'(n_last[1]), 32'(N));
    chk("job_done1", 32'(n_done[0]), 32'd1);
    chk("job_done3", 32'(n_done[1]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy1), 32'd0);
    chk("reset_done", 32'(done3), 32'd0);
    chk("reset_src_rdy", 32'(if1.src_rdy), 32'd0);
    chk("reset_ena", 32'(if3.ram_ena), 32'd0);
    chk("reset_addra", 32'(if1.ram_addra), 32'd0);
    chk("reset_mac_vld", 32'(if3.mac_vld), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    do_job(0, 1'b0, 0, 1'b0);
    do_job(1, 1'b1, 0, 1'b1);
    do_job(2, 1'b0, 10, 1'b1);
    do_job(0, 1'b0, 0, 1'b0);
    repeat (3) do_job(2, 1'b1, 0, 1'b1);
    tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
